cv32e40x_div_issue: RTL and testbench
=====================================

Name: cv32e40x_div_issue

Overview:
- Issue and retire wrapper between the EX-stage pipeline register and the serial divider.
- Accepts one DIV/DIVU/REM/REMU request per handshake and latches operator, operands and destination tag.
- Holds divider valid and operands stable for the whole divide, which the divider requires.
- Captures the divider result into a holding register and presents it to writeback with valid/ready backpressure. Supports kill (flush) at any point.

Parameters:
- C_WIDTH, 32, operand/result width
- TAG_WIDTH, 5, destination register tag width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- valid_i  input  1  upstream request valid
- ready_o  output  1  upstream request accepted
- operator_i  input  div_opcode_e  requested operation
- op_a_i  input  C_WIDTH  dividend
- op_b_i  input  C_WIDTH  divisor
- tag_i  input  TAG_WIDTH  destination tag
- kill_i  input  1  flush in-flight and held operation
- div_valid_o  output  1  divider request valid (held)
- div_ready_i  input  1  divider input ready
- div_operator_o  output  div_opcode_e  latched operator
- div_op_a_o  output  C_WIDTH  latched dividend
- div_op_b_o  output  C_WIDTH  latched divisor
- div_valid_i  input  1  divider result valid
- div_ready_o  output  1  result accepted from divider
- div_result_i  input  C_WIDTH  divider result
- valid_o  output  1  result valid to writeback
- ready_i  input  1  writeback ready
- result_o  output  C_WIDTH  held result
- tag_o  output  TAG_WIDTH  tag of held result

Behaviour:
- Clock/reset: single clock clk; asynchronous active-low reset rst_n.
- Reset: state IDLE; all registers cleared; valid_o=0, div_valid_o=0, result_o=0, tag_o=0, div_op_a_o=div_op_b_o=0, div_operator_o=DIV_DIVU. ready_o=1 once out of reset while kill_i=0.
- States (div_issue_state_e): ISSUE_IDLE, ISSUE_BUSY, ISSUE_DONE.
- ready_o = !kill_i && (IDLE || (DONE && ready_i)). Accept = valid_i && ready_o; it latches operator, operands and tag, then moves to BUSY.
- div_valid_o = (state==BUSY), fully registered. The divider sees valid at the earliest one cycle after accept.
- div_op_*_o and div_operator_o come straight from registers and are stable throughout BUSY.
- In BUSY: div_ready_o=1. On div_valid_i, capture div_result_i into the result register and move to DONE. div_valid_o drops in the cycle after capture, so the divider returns to idle without restarting.
- div_ready_o=0 outside BUSY.
- In DONE: valid_o=1 and result_o/tag_o are stable until ready_i. On ready_i, go to IDLE, or to BUSY if a new request is accepted in the same cycle (back-to-back). The divider always sees at least one cycle with valid low between operations.
- Latency: accept to valid_o = divider latency + 2 cycles.
- kill_i has priority over every other event:
  - BUSY: go to IDLE; div_valid_o=0 next cycle, which aborts the divider.
  - DONE: result discarded; valid_o=0 next cycle.
  - Same cycle as valid_i: nothing accepted.
- kill_i with div_valid_i in the same BUSY cycle: the result is dropped.
- Asserting rst_n mid-divide returns the block to reset values immediately.
- div_ready_i is informational only; assert that it is 1 whenever div_valid_o rises.

Optional Feature:
- Macro: CV32E40X_DIV_ZERO_BYPASS_EN.
- Defined: an accepted request with op_b_i==0 does not engage the divider. The block goes directly to DONE with result 0xFFFFFFFF (DIV/DIVU) or op_a_i (REM/REMU), giving 1-cycle accept-to-valid_o latency. div_valid_o stays 0 throughout.
- Undefined: divide-by-zero takes the normal BUSY path, and the divider produces the same RISC-V-mandated values.

Decomposition:
- cv32e40x_pkg gains the div_issue_state_e enum. div_opcode_e is reused unchanged.
- No sub-module: one FSM plus operand and result registers is natural as a single module.

Test Plan:
- DIV 100/7, ready_i=1 → result_o=14, tag_o=tag_i, valid_o for exactly 1 cycle; div_valid_o drops 1 cycle after capture.
- REM 0xFFFFFFF9 (-7) by 2 with ready_i low for 5 cycles → valid_o held, result_o=0xFFFFFFFF stable; ready_o=0 throughout.
- DIVU 0x12345678/0 → result_o=0xFFFFFFFF. With CV32E40X_DIV_ZERO_BYPASS_EN, valid_o 1 cycle after accept and div_valid_o never asserted.
- kill_i pulsed 5 cycles into BUSY for DIV 1000/3 → no valid_o, div_valid_o=0 next cycle. A subsequent REMU 10/4 → 2.
- Back-to-back: DIVU 9/3 then REMU 9/4 offered while DONE && ready_i → results 3 then 1, and div_valid_o low for at least 1 cycle between them.
- Assert rst_n=0 during BUSY → all outputs return to reset values; the next DIV 6/2 → 3.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared types for the cv32e40x divider issue slice.
// div_opcode_e is the existing divider opcode; div_issue_state_e is the issue FSM state.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    DIV_DIVU = 2'b00,
    DIV_DIV  = 2'b01,
    DIV_REMU = 2'b10,
    DIV_REM  = 2'b11
  } div_opcode_e;

  typedef enum logic [1:0] {
    ISSUE_IDLE = 2'b00,
    ISSUE_BUSY = 2'b01,
    ISSUE_DONE = 2'b10
  } div_issue_state_e;

  function automatic logic div_is_rem(div_opcode_e op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

endpackage

// File: rtl/cv32e40x_div_issue.sv
// Issue/retire wrapper between the EX pipeline register and the serial divider.
// Optional CV32E40X_DIV_ZERO_BYPASS_EN answers divide-by-zero without engaging the divider.
module cv32e40x_div_issue
  import cv32e40x_pkg::*;
#(
  parameter int C_WIDTH   = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  div_opcode_e          operator_i,
  input  logic [C_WIDTH-1:0]   op_a_i,
  input  logic [C_WIDTH-1:0]   op_b_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic                 kill_i,
  output logic                 div_valid_o,
  input  logic                 div_ready_i,
  output div_opcode_e          div_operator_o,
  output logic [C_WIDTH-1:0]   div_op_a_o,
  output logic [C_WIDTH-1:0]   div_op_b_o,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  input  logic [C_WIDTH-1:0]   div_result_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [C_WIDTH-1:0]   result_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  div_issue_state_e     state_d, state_q;
  div_opcode_e          operator_d, operator_q;
  logic [C_WIDTH-1:0]   op_a_d, op_a_q;
  logic [C_WIDTH-1:0]   op_b_d, op_b_q;
  logic [TAG_WIDTH-1:0] tag_d, tag_q;
  logic [C_WIDTH-1:0]   result_d, result_q;
  logic                 accept;
  logic                 bypass;

  assign ready_o = !kill_i && ((state_q == ISSUE_IDLE) || ((state_q == ISSUE_DONE) && ready_i));
  assign accept  = valid_i && ready_o;

`ifdef CV32E40X_DIV_ZERO_BYPASS_EN
  assign bypass = accept && (op_b_i == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    operator_d = operator_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    tag_d      = tag_q;
    result_d   = result_q;

    if (accept) begin
      operator_d = operator_i;
      op_a_d     = op_a_i;
      op_b_d     = op_b_i;
      tag_d      = tag_i;
      if (bypass) begin
        result_d = div_is_rem(operator_i) ? op_a_i : '1;
      end
    end

    // kill wins over every other event, including a divider result in the same cycle
    if (kill_i) begin
      state_d = ISSUE_IDLE;
    end else begin
      unique case (state_q)
        ISSUE_IDLE: begin
          if (accept) state_d = bypass ? ISSUE_DONE : ISSUE_BUSY;
        end
        ISSUE_BUSY: begin
          if (div_valid_i) begin
            state_d  = ISSUE_DONE;
            result_d = div_result_i;
          end
        end
        ISSUE_DONE: begin
          if (ready_i) begin
            if (accept) state_d = bypass ? ISSUE_DONE : ISSUE_BUSY;
            else        state_d = ISSUE_IDLE;
          end
        end
        default: state_d = ISSUE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ISSUE_IDLE;
      operator_q <= DIV_DIVU;
      op_a_q     <= '0;
      op_b_q     <= '0;
      tag_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      operator_q <= operator_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      tag_q      <= tag_d;
      result_q   <= result_d;
    end
  end

  // Divider valid is purely state-derived, so it always drops for a cycle between operations.
  assign div_valid_o    = (state_q == ISSUE_BUSY);
  assign div_ready_o    = (state_q == ISSUE_BUSY);
  assign div_operator_o = operator_q;
  assign div_op_a_o     = op_a_q;
  assign div_op_b_o     = op_b_q;
  assign valid_o        = (state_q == ISSUE_DONE);
  assign result_o       = result_q;
  assign tag_o          = tag_q;

  div_ready_on_issue: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(div_valid_o) |-> div_ready_i);

endmodule

// File: tb/tb_cv32e40x_div_issue.sv
// Randomised and directed bench for cv32e40x_div_issue with a serial-divider stand-in
// and a transaction-level reference model (at most one operation outstanding).
module tb_cv32e40x_div_issue;
  import cv32e40x_pkg::*;

`ifdef CV32E40X_DIV_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  div_opcode_e operator_i = DIV_DIVU;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic [4:0]  tag_i = '0;
  logic        kill_i = 1'b0;
  logic        div_valid_o;
  logic        div_ready_i;
  div_opcode_e div_operator_o;
  logic [31:0] div_op_a_o;
  logic [31:0] div_op_b_o;
  logic        div_valid_i;
  logic        div_ready_o;
  logic [31:0] div_result_i;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] result_o;
  logic [4:0]  tag_o;

  cv32e40x_div_issue dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .tag_i(tag_i),
    .kill_i(kill_i), .div_valid_o(div_valid_o), .div_ready_i(div_ready_i),
    .div_operator_o(div_operator_o), .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o),
    .div_valid_i(div_valid_i), .div_ready_o(div_ready_o), .div_result_i(div_result_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // RISC-V M-extension division semantics, including the divide-by-zero and overflow cases.
  function automatic logic [31:0] ref_div(div_opcode_e op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      DIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      DIV_REMU: return (b == 0) ? a : a % b;
      DIV_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Serial divider stand-in: fixed latency per operation, aborts when its valid drops.
  int          lat_cfg = 3;
  int          m_cnt;
  bit          m_busy;
  div_opcode_e m_op;
  logic [31:0] m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy       <= 1'b0;
      m_cnt        <= 0;
      m_op         <= DIV_DIVU;
      m_a          <= '0;
      m_b          <= '0;
      div_valid_i  <= 1'b0;
      div_ready_i  <= 1'b1;
      div_result_i <= '0;
    end else if (m_busy) begin
      if (!div_valid_o || (div_valid_i && div_ready_o)) begin
        m_busy      <= 1'b0;
        div_valid_i <= 1'b0;
        div_ready_i <= 1'b1;
      end else if (!div_valid_i) begin
        if (m_cnt == 0) begin
          div_valid_i  <= 1'b1;
          div_result_i <= ref_div(m_op, m_a, m_b);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end else if (div_valid_o && div_ready_i) begin
      m_busy      <= 1'b1;
      m_op        <= div_operator_o;
      m_a         <= div_op_a_o;
      m_b         <= div_op_b_o;
      m_cnt       <= lat_cfg;
      div_ready_i <= 1'b0;
    end
  end

  // Reference model: the single outstanding operation and whether its result is ready.
  bit          m_have = 1'b0;
  bit          m_done;
  logic [31:0] m_res, m_ea, m_eb;
  logic [4:0]  m_tag;
  div_opcode_e m_eop;
  bit          last_acc, last_xfer;
  logic [31:0] got[$];

  bit          drv_valid = 1'b0, drv_kill = 1'b0, drv_ready = 1'b0;
  div_opcode_e drv_op = DIV_DIVU;
  logic [31:0] drv_a = '0, drv_b = '0;
  logic [4:0]  drv_tag = '0;

  task automatic check_and_update();
    bit exp_ready;
    exp_ready = !kill_i && (!m_have || (m_done && ready_i));
    chk("ready_o", 32'(ready_o), 32'(exp_ready));
    chk("valid_o", 32'(valid_o), 32'(m_have && m_done));
    chk("div_valid_o", 32'(div_valid_o), 32'(m_have && !m_done));
    chk("div_ready_o", 32'(div_ready_o), 32'(m_have && !m_done));
    if (m_have && m_done) begin
      chk("result_o", result_o, m_res);
      chk("tag_o", 32'(tag_o), 32'(m_tag));
    end
    if (m_have && !m_done) begin
      chk("div_op_a_o", div_op_a_o, m_ea);
      chk("div_op_b_o", div_op_b_o, m_eb);
      chk("div_operator_o", 32'(div_operator_o), 32'(m_eop));
    end
    last_acc  = valid_i && exp_ready;
    last_xfer = m_have && m_done && ready_i && !kill_i;
    if (kill_i) begin
      m_have = 1'b0;
    end else begin
      if (m_have && !m_done && div_valid_i) m_done = 1'b1;
      if (last_xfer) begin
        m_have = 1'b0;
        got.push_back(result_o);
        $display("xfer tag=%0d result=%h", tag_o, result_o);
      end
      if (last_acc) begin
        m_have = 1'b1;
        m_done = BYPASS && (op_b_i == 0);
        m_res  = ref_div(operator_i, op_a_i, op_b_i);
        m_ea   = op_a_i;
        m_eb   = op_b_i;
        m_eop  = operator_i;
        m_tag  = tag_i;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    valid_i    = drv_valid;
    kill_i     = drv_kill;
    ready_i    = drv_ready;
    operator_i = drv_op;
    op_a_i     = drv_a;
    op_b_i     = drv_b;
    tag_i      = drv_tag;
    #1;
    if (rst_n) check_and_update();
    else begin
      last_acc  = 1'b0;
      last_xfer = 1'b0;
    end
  endtask

  task automatic offer(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    int n;
    drv_valid = 1'b1; drv_op = op; drv_a = a; drv_b = b; drv_tag = tag; drv_ready = 1'b0;
    n = 0;
    do begin step(); n++; end while (!last_acc && n < 100);
    if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
    drv_valid = 1'b0;
  endtask

  task automatic wait_xfer(input int hold);
    int n, held;
    n = 0;
    held = 0;
    do begin
      drv_ready = (held >= hold);
      step();
      if (valid_o) held++;
      n++;
    end while (!last_xfer && n < 200);
    if (!last_xfer) chk("result_timeout", 32'd0, 32'd1);
    drv_ready = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_div_valid_o", 32'(div_valid_o), 32'd0);
    chk("rst_div_ready_o", 32'(div_ready_o), 32'd0);
    chk("rst_result_o", result_o, 32'd0);
    chk("rst_tag_o", 32'(tag_o), 32'd0);
    chk("rst_div_op_a_o", div_op_a_o, 32'd0);
    chk("rst_div_op_b_o", div_op_b_o, 32'd0);
    chk("rst_div_operator_o", 32'(div_operator_o), 32'(DIV_DIVU));
  endtask

  initial begin
    logic [31:0] exp_got[7];
    exp_got = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'd1, 32'd3};

    // model pins
    chk("ref_div_100_7", ref_div(DIV_DIV, 32'd100, 32'd7), 32'd14);
    chk("ref_rem_m7_2", ref_div(DIV_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("ref_div_ovf", ref_div(DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("ref_remu_zero", ref_div(DIV_REMU, 32'd7, 32'd0), 32'd7);

    repeat (2) @(negedge clk);
    #1 check_reset_values();
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_ready_o", 32'(ready_o), 32'd1);

    lat_cfg = 4;
    offer(DIV_DIV, 32'd100, 32'd7, 5'd3);
    wait_xfer(0);
    offer(DIV_REM, 32'hFFFF_FFF9, 32'd2, 5'd7);
    wait_xfer(5);
    offer(DIV_DIVU, 32'h1234_5678, 32'd0, 5'd9);
    wait_xfer(0);

    // kill five cycles into a long divide
    lat_cfg = 12;
    offer(DIV_DIV, 32'd1000, 32'd3, 5'd11);
    repeat (5) step();
    drv_kill = 1'b1;
    step();
    drv_kill = 1'b0;
    step();
    chk("kill_div_valid_o", 32'(div_valid_o), 32'd0);
    repeat (15) step();
    lat_cfg = 2;
    offer(DIV_REMU, 32'd10, 32'd4, 5'd12);
    wait_xfer(0);

    // back-to-back: second request offered while the first is held with ready_i high
    lat_cfg = 3;
    offer(DIV_DIVU, 32'd9, 32'd3, 5'd13);
    drv_valid = 1'b1; drv_op = DIV_REMU; drv_a = 32'd9; drv_b = 32'd4; drv_tag = 5'd14;
    drv_ready = 1'b1;
    begin
      int n = 0;
      do begin step(); n++; end while (!last_xfer && n < 100);
      chk("b2b_first_xfer", 32'(last_xfer), 32'd1);
      chk("b2b_same_cycle_accept", 32'(last_acc), 32'd1);
      chk("b2b_div_valid_gap", 32'(div_valid_o), 32'd0);
    end
    drv_valid = 1'b0;
    wait_xfer(0);

    // asynchronous reset in the middle of a divide
    lat_cfg = 12;
    offer(DIV_DIV, 32'd50, 32'd5, 5'd15);
    repeat (3) step();
    @(negedge clk) rst_n = 1'b0;
    #1 check_reset_values();
    m_have = 1'b0;
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    lat_cfg = 1;
    offer(DIV_DIV, 32'd6, 32'd2, 5'd16);
    wait_xfer(0);

    chk("got_count", 32'(got.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < got.size()) chk($sformatf("got[%0d]", i), got[i], exp_got[i]);
    end

    // randomised traffic including kills, zero divisors and signed overflow
    for (int c = 0; c < 1500; c++) begin
      int sel;
      drv_valid = ($urandom % 2) == 0;
      drv_op    = div_opcode_e'($urandom % 4);
      drv_a     = $urandom;
      sel       = $urandom % 8;
      drv_b     = (sel == 0) ? 32'd0 : (sel < 3) ? ($urandom % 9) : $urandom;
      if (sel == 7) begin
        drv_a = 32'h8000_0000;
        drv_b = 32'hFFFF_FFFF;
      end
      drv_tag   = 5'($urandom);
      drv_kill  = ($urandom % 25) == 0;
      drv_ready = ($urandom % 3) != 0;
      lat_cfg   = $urandom % 6;
      step();
    end
    drv_valid = 1'b0;
    drv_kill  = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
